// File: rtl/hc_mux_scan_if.sv
`default_nettype none
// ============================================================================
//  Module      : hc_mux_scan_if
//  Description : Control/data bundle for the hc_mux_scan multiplexer/scanner.
//                Carries the input words, the select controls, the per-channel
//                output enables and the select/wrap status back to the master.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Signals
//    d       CH*N*WIDTH  input words; word (c,i) at [(c*N+i)*WIDTH +: WIDTH]
//    hold    1           1 = data register keeps its value
//    sel     SEL_W       manual select value
//    sel_le  1           manual select load strobe
//    mode    1           0 = manual select, 1 = scan
//    oe_n    CH          per-channel output enable, active-low
//    cur_sel SEL_W       current select register value
//    wrap    1           one-cycle pulse after the scan select wraps to 0
//  Modports
//    master  drives the controls, observes status (board / bench side)
//    slave   the multiplexer itself
// ============================================================================
interface hc_mux_scan_if #(
    parameter int WIDTH = 1,
    parameter int SEL_W = 2,
    parameter int CH    = 2
);
    localparam int c_N = 1 << SEL_W;

    logic [CH*c_N*WIDTH-1:0] d;
    logic                    hold;
    logic [SEL_W-1:0]        sel;
    logic                    sel_le;
    logic                    mode;
    logic [CH-1:0]           oe_n;
    logic [SEL_W-1:0]        cur_sel;
    logic                    wrap;

    modport master (
        output d,
        output hold,
        output sel,
        output sel_le,
        output mode,
        output oe_n,
        input  cur_sel,
        input  wrap
    );

    modport slave (
        input  d,
        input  hold,
        input  sel,
        input  sel_le,
        input  mode,
        input  oe_n,
        output cur_sel,
        output wrap
    );
endinterface
`default_nettype wire

// File: rtl/hc_mux_scan.sv
`default_nettype none
// ============================================================================
//  Module      : hc_mux_scan
//  Description : CH-channel, 2^SEL_W-input registered multiplexer with
//                per-channel active-low 3-state output enables and a scan
//                mode that steps the shared select through every input at
//                a programmable rate, pulsing wrap after each N-1 -> 0 step.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH     bits per input word
//    SEL_W     select width; N = 2^SEL_W inputs per channel
//    CH        number of channels (all share one select)
//    SCAN_DIV  clocks per scan step in scan mode (>= 1)
//  Ports
//    clk       rising-edge clock
//    rst       asynchronous reset, active-high
//    bus       hc_mux_scan_if.slave: d, hold, sel, sel_le, mode, oe_n in;
//              cur_sel, wrap out
//    y         CH*WIDTH 3-state channel outputs, channel c at [c*WIDTH +: WIDTH]
//  Build option
//    HC_MUX_SYNC_OE_EN  when defined, oe_n is registered per channel (reset to
//                       all 1s, i.e. outputs Z) and takes effect one clock
//                       after it is sampled; otherwise oe_n acts
//                       combinationally. The port list is the same either way.
// ============================================================================
module hc_mux_scan #(
    parameter int WIDTH    = 1,
    parameter int SEL_W    = 2,
    parameter int CH       = 2,
    parameter int SCAN_DIV = 1
) (
    input  wire                    clk,
    input  wire                    rst,
    hc_mux_scan_if.slave           bus,
    // The 3-state outputs stay a plain net port so they can be resolved with
    // other drivers on a shared board-level bus.
    output wire [CH*WIDTH-1:0]     y
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_N    = 1 << SEL_W;
    // Prescaler width is max(1, clog2(SCAN_DIV)); SCAN_DIV = 1 or 2 both fit
    // in a single bit.
    localparam int c_PS_W = (SCAN_DIV <= 2) ? 1 : $clog2(SCAN_DIV);

    localparam logic [c_PS_W-1:0] c_PS_MAX  = c_PS_W'(SCAN_DIV - 1);
    localparam logic [c_PS_W-1:0] c_PS_ONE  = c_PS_W'(1);
    localparam logic [SEL_W-1:0]  c_SEL_MAX = '1;
    localparam logic [SEL_W-1:0]  c_SEL_ONE = SEL_W'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [CH*c_N*WIDTH-1:0] r_data;    // captured input words
    logic [SEL_W-1:0]        r_sel;     // shared select register
    logic [c_PS_W-1:0]       r_ps;      // scan-rate prescaler
    logic                    r_wrap;    // registered wrap pulse

    logic [CH-1:0]           w_oe_n;    // effective per-channel disable

    // ------------------------------------------------------------------------
    // Data, select and scan sequencing
    //
    // The data register and the select path are deliberately independent:
    // with hold=1 the select can still move, re-selecting among frozen words.
    //
    // In manual mode the prescaler is parked at 0, so a switch into scan mode
    // always begins a full SCAN_DIV-clock step from the current select value.
    // Leaving scan mode simply stops the increment; the select freezes where
    // it is and wrap drops on the next edge.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_sel  <= '0;
            r_ps   <= '0;
            r_wrap <= 1'b0;
        end else begin
            if (!bus.hold) begin
                r_data <= bus.d;
            end

            // wrap defaults low; it is raised only for the edge that carries
            // the select from N-1 back to 0.
            r_wrap <= 1'b0;

            if (bus.mode) begin
                // sel_le is ignored while scanning.
                if (r_ps == c_PS_MAX) begin
                    r_ps   <= '0;
                    r_sel  <= r_sel + c_SEL_ONE;   // natural wrap modulo N
                    r_wrap <= (r_sel == c_SEL_MAX);
                end else begin
                    r_ps   <= r_ps + c_PS_ONE;
                end
            end else begin
                r_ps <= '0;
                if (bus.sel_le) begin
                    r_sel <= bus.sel;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Output-enable path
    // ------------------------------------------------------------------------
`ifdef HC_MUX_SYNC_OE_EN
    logic [CH-1:0] r_oe_n;

    // Reset to all 1s keeps every channel floating through reset and until
    // the first edge that samples an enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_oe_n <= '1;
        end else begin
            r_oe_n <= bus.oe_n;
        end
    end

    assign w_oe_n = r_oe_n;
`else
    // Enables act immediately, independent of the clock.
    assign w_oe_n = bus.oe_n;
`endif

    // ------------------------------------------------------------------------
    // Word unpacking: present the flat data register as [channel][input] so
    // the output select is a plain array index rather than computed slicing.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:0] w_words [CH][c_N];

    for (genvar c = 0; c < CH; c++) begin : g_word_ch
        for (genvar i = 0; i < c_N; i++) begin : g_word_in
            assign w_words[c][i] = r_data[(c*c_N + i)*WIDTH +: WIDTH];
        end
    end

    // ------------------------------------------------------------------------
    // Channel outputs: combinational from the registers, so data and select
    // sampled at one edge appear on y right after that edge.
    // ------------------------------------------------------------------------
    for (genvar c = 0; c < CH; c++) begin : g_out_ch
        assign y[c*WIDTH +: WIDTH] = w_oe_n[c] ? {WIDTH{1'bz}}
                                               : w_words[c][r_sel];
    end

    // ------------------------------------------------------------------------
    // Status outputs (never 3-state)
    // ------------------------------------------------------------------------
    assign bus.cur_sel = r_sel;
    assign bus.wrap    = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_hc_mux_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hc_mux_scan
//  Description : Self-checking bench for hc_mux_scan. A behavioural model
//                derives the select from the number of clocks spent scanning
//                since scan mode was entered; every output is compared after
//                each clock and after asynchronous events.
//                Honours HC_MUX_SYNC_OE_EN when the build defines it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hc_mux_scan;

    localparam int W   = 4;
    localparam int SW  = 2;
    localparam int CH  = 2;
    localparam int DIV = 3;
    localparam int N   = 1 << SW;
    localparam int DW  = CH * N * W;

    logic clk = 1'b0;
    logic rst;
    wire  [CH*W-1:0] y;

    always #5 clk = ~clk;

    hc_mux_scan_if #(.WIDTH(W), .SEL_W(SW), .CH(CH)) bus ();

    hc_mux_scan #(
        .WIDTH    (W),
        .SEL_W    (SW),
        .CH       (CH),
        .SCAN_DIV (DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave),
        .y   (y)
    );

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    logic [W-1:0]  m_data [CH][N];
    int            m_sel;
    int            m_base;     // select value when scanning began
    int            m_cyc;      // clocks spent scanning since then
    logic          m_wrap;
    logic [CH-1:0] m_oe_q;     // sampled enables (registered-enable build)

    task automatic model_reset();
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < N; i++)
                m_data[c][i] = '0;
        m_sel  = 0;
        m_base = 0;
        m_cyc  = 0;
        m_wrap = 1'b0;
        m_oe_q = '1;
    endtask

    task automatic model_edge();
        int nxt;
        if (rst) begin
            model_reset();
            return;
        end
        m_oe_q = bus.oe_n;
        if (!bus.hold)
            for (int c = 0; c < CH; c++)
                for (int i = 0; i < N; i++)
                    m_data[c][i] = bus.d[(c*N + i)*W +: W];
        if (bus.mode) begin
            m_cyc  = m_cyc + 1;
            nxt    = (m_base + m_cyc / DIV) % N;
            m_wrap = ((m_cyc % DIV) == 0) && (nxt == 0);
            m_sel  = nxt;
        end else begin
            m_wrap = 1'b0;
            if (bus.sel_le) m_sel = int'(bus.sel);
            m_base = m_sel;
            m_cyc  = 0;
        end
    endtask

    task automatic check_all(input string tag);
        logic [CH*W-1:0] ey;
        logic [CH-1:0]   oe_eff;
`ifdef HC_MUX_SYNC_OE_EN
        oe_eff = m_oe_q;
`else
        oe_eff = bus.oe_n;
`endif
        for (int c = 0; c < CH; c++)
            ey[c*W +: W] = oe_eff[c] ? {W{1'bz}} : m_data[c][m_sel];
        checks++;
        assert (y === ey) else begin
            failures++;
            $error("FAIL %s.y observed=%h expected=%h", tag, y, ey);
        end
        checks++;
        assert (bus.cur_sel === SW'(m_sel)) else begin
            failures++;
            $error("FAIL %s.cur_sel observed=%0d expected=%0d", tag, bus.cur_sel, m_sel);
        end
        checks++;
        assert (bus.wrap === m_wrap) else begin
            failures++;
            $error("FAIL %s.wrap observed=%b expected=%b", tag, bus.wrap, m_wrap);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic rand_d();
        bus.d = DW'($urandom);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit reached;

        bus.d      = '1;
        bus.hold   = 1'b0;
        bus.sel    = '0;
        bus.sel_le = 1'b0;
        bus.mode   = 1'b0;
        bus.oe_n   = 2'b10;
        rst        = 1'b1;
        model_reset();

        // Reset state: channel 0 drives 0, channel 1 floats.
        #3;
        check_all("reset");
        tick();
        check_all("reset_edge");

        // Release and capture all-ones data.
        @(negedge clk);
        rst = 1'b0;
        tick();
        check_all("first_edge");

        // Manual select: ch0 words 1,0,1,0 pattern.
        bus.d      = {16'($urandom), 16'h0F0F};
        bus.sel    = 2'd1;
        bus.sel_le = 1'b1;
        tick();
        check_all("man_load");
        bus.sel    = 2'd3;
        bus.sel_le = 1'b0;
        tick();
        check_all("man_noload");

        // Random manual traffic.
        for (int k = 0; k < 16; k++) begin
            rand_d();
            bus.hold   = 1'($urandom_range(0, 1));
            bus.sel    = SW'($urandom);
            bus.sel_le = 1'($urandom_range(0, 1));
            bus.oe_n   = CH'($urandom);
            tick();
            check_all("man_rand");
        end

        // Scan from select 2 with both channels enabled.
        bus.hold   = 1'b0;
        bus.oe_n   = '0;
        bus.sel    = 2'd2;
        bus.sel_le = 1'b1;
        tick();
        check_all("scan_setup");
        bus.mode = 1'b1;
        for (int k = 0; k < 2*N*DIV + 2; k++) begin
            rand_d();
            bus.sel    = SW'($urandom);
            bus.sel_le = 1'($urandom_range(0, 1));
            tick();
            check_all("scan");
        end

        // Hold: invert the inputs, outputs must keep selecting frozen words.
        bus.hold = 1'b1;
        bus.d    = ~bus.d;
        for (int k = 0; k < 8*DIV; k++) begin
            tick();
            check_all("hold");
        end
        bus.hold = 1'b0;
        tick();
        check_all("hold_release");

        // Async reset mid-scan once the select reaches 3.
        reached = 1'b0;
        for (int k = 0; k < 4*N*DIV && !reached; k++) begin
            tick();
            check_all("scan_to3");
            if (m_sel == 3) reached = 1'b1;
        end
        checks++;
        assert (reached) else begin
            failures++;
            $error("FAIL scan_reach3 observed=%0d expected=3", m_sel);
        end
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_all("async_rst");
        #1;
        rst = 1'b0;
        for (int k = 0; k < DIV; k++) begin
            tick();
            check_all("post_rst");
        end

        // Mixed random traffic including mode switches both ways.
        for (int k = 0; k < 80; k++) begin
            rand_d();
            if ($urandom_range(0, 7) == 0) bus.mode = ~bus.mode;
            bus.hold   = ($urandom_range(0, 3) == 0);
            bus.sel    = SW'($urandom);
            bus.sel_le = 1'($urandom_range(0, 1));
            bus.oe_n   = CH'($urandom);
            tick();
            check_all("mixed");
        end

        // Enable change between edges.
        bus.mode = 1'b0;
        bus.oe_n = 2'b11;
        tick();
        check_all("oe_off");
        bus.oe_n = 2'b10;
        #1;
        check_all("oe_between");
        tick();
        check_all("oe_after_edge");
        bus.oe_n = 2'b01;
        #1;
        check_all("oe_swap");
        tick();
        check_all("oe_swap_edge");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
